ram_arbiter: RTL and testbench

- Sequences every access to the shared 32Kx8 cartridge SRAM.
- Two requesters share it:
  - Atari cart side: hard deadline, bound to fi2 edges, always has priority.
  - Microcontroller side: level request with 4-phase ack handshake.
- Generates ram_addr, ram_wdata, the data-drive enable and the active-low strobes with a fixed clk-counted access window.
- Replaces ad-hoc state bits in the top level.

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/fi2_edge_sync.sv | 22 ++
 rtl/ram_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_ram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the cartridge SRAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CART_ACC = 2'd1,
    UC_ACC   = 2'd2
  } state_t;

  localparam int DEF_PHASES   = 4;
  localparam int DEF_WE_FIRST = 1;
  localparam int DEF_WE_LAST  = 2;

  // Width of the access counter that runs 0..phases-1
  function automatic int cnt_width(input int phases);
    return (phases > 2) ? $clog2(phases) : 1;
  endfunction

endpackage

// File: rtl/fi2_edge_sync.sv
// Brings the Atari phi2 into the clk domain and flags its edges.
module fi2_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic fi2,
  output logic rise,
  output logic fall
);

  // [0],[1]: metastability synchroniser; [2]: previous synchronised level
  logic [2:0] sync_q;

  // Shift the pad level through the synchroniser and history flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], fi2};
  end

  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/ram_arbiter.sv
// Sequences cart and microcontroller accesses to the shared cartridge SRAM.
// Cart requests are tied to phi2 and always win; the uc uses a 4-phase handshake.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 8,
  parameter int PHASES   = DEF_PHASES,
  parameter int WE_FIRST = DEF_WE_FIRST,
  parameter int WE_LAST  = DEF_WE_LAST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fi2,
  input  logic              cart_rd,
  input  logic              cart_wr,
  input  logic [ADDR_W-1:0] cart_addr,
  input  logic [DATA_W-1:0] cart_wdata,
  output logic [DATA_W-1:0] cart_rdata,
  input  logic              uc_req,
  input  logic              uc_we,
  input  logic [ADDR_W-1:0] uc_addr,
  input  logic [DATA_W-1:0] uc_wdata,
  output logic [DATA_W-1:0] uc_rdata,
  output logic              uc_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_drive,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic              busy,
  output logic              cart_overrun
);

  localparam int            CW       = cnt_width(PHASES);
  localparam logic [CW-1:0] CNT_LAST = CW'(PHASES - 1);
  localparam logic [CW-1:0] CNT_SAMP = CW'(PHASES - 2);
  localparam logic [CW-1:0] CNT_WE_F = CW'(WE_FIRST);
  localparam logic [CW-1:0] CNT_WE_L = CW'(WE_LAST);

  logic              rise, fall;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              start_cart, start_uc;
  logic              acc_d, wr_d;
  logic              pend, pend_wr;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_wdata;
  logic              act_cart, act_wr;

  fi2_edge_sync u_fi2_sync (
    .clk   (clk),
    .reset (reset),
    .fi2   (fi2),
    .rise  (rise),
    .fall  (fall)
  );

  // State register and access-phase counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: pending cart request outranks uc; each access is PHASES clk long
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    start_cart = 1'b0;
    start_uc   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pend) begin
          state_d    = CART_ACC;
          start_cart = 1'b1;
        end else if (fall && uc_req && !uc_ack) begin
          state_d  = UC_ACC;
          start_uc = 1'b1;
        end
      end
      CART_ACC, UC_ACC: begin
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign acc_d = (state_d != IDLE);
  assign wr_d  = start_cart ? pend_wr : (start_uc ? uc_we : act_wr);

  // Capture a cart request on phi2 rise; one arriving while still pending is lost
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend         <= 1'b0;
      pend_wr      <= 1'b0;
      pend_addr    <= '0;
      pend_wdata   <= '0;
      cart_overrun <= 1'b0;
    end else begin
      if (start_cart) pend <= 1'b0;
      if (rise && (cart_rd || cart_wr)) begin
        if (pend) begin
          cart_overrun <= 1'b1;
        end else begin
          pend       <= 1'b1;
          pend_wr    <= cart_wr;
          pend_addr  <= cart_addr;
          pend_wdata <= cart_wdata;
        end
      end
    end
  end

  // Load the winning request at access start; address/data hold through IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
      act_cart  <= 1'b0;
      act_wr    <= 1'b0;
    end else if (start_cart) begin
      ram_addr  <= pend_addr;
      ram_wdata <= pend_wdata;
      act_cart  <= 1'b1;
      act_wr    <= pend_wr;
    end else if (start_uc) begin
      ram_addr  <= uc_addr;
      ram_wdata <= uc_wdata;
      act_cart  <= 1'b0;
      act_wr    <= uc_we;
    end
  end

  // Strobes registered from the next state so they track cnt without glitches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      ram_drive <= 1'b0;
      ram_oe_n  <= 1'b1;
      ram_we_n  <= 1'b1;
    end else begin
      busy      <= acc_d;
      ram_drive <= acc_d & wr_d;
      ram_oe_n  <= ~(acc_d & ~wr_d);
      ram_we_n  <= ~(acc_d & wr_d & (cnt_d >= CNT_WE_F) & (cnt_d <= CNT_WE_L));
    end
  end

  // Sample read data one cycle before the access ends into the owner's latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cart_rdata <= '0;
      uc_rdata   <= '0;
    end else if (state_q != IDLE && !act_wr && cnt_q == CNT_SAMP) begin
      if (act_cart) cart_rdata <= ram_rdata;
      else          uc_rdata   <= ram_rdata;
    end
  end

  // uc ack: set after the final uc cycle, cleared once uc_req is seen low
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       uc_ack <= 1'b0;
    else if (state_q == UC_ACC && cnt_q == CNT_LAST) uc_ack <= 1'b1;
    else if (!uc_req)                                uc_ack <= 1'b0;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 32Kx8 SRAM.
module tb_ram_arbiter;

  localparam int AW = 15;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fi2 = 1'b0;
  logic          cart_rd = 1'b0, cart_wr = 1'b0;
  logic [AW-1:0] cart_addr = '0;
  logic [DW-1:0] cart_wdata = '0;
  logic [DW-1:0] cart_rdata;
  logic          uc_req = 1'b0, uc_we = 1'b0;
  logic [AW-1:0] uc_addr = '0;
  logic [DW-1:0] uc_wdata = '0;
  logic [DW-1:0] uc_rdata;
  logic          uc_ack;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          ram_drive, ram_oe_n, ram_we_n, busy, cart_overrun;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] mem [0:32767];

  ram_arbiter dut (
    .clk(clk), .reset(reset), .fi2(fi2),
    .cart_rd(cart_rd), .cart_wr(cart_wr), .cart_addr(cart_addr),
    .cart_wdata(cart_wdata), .cart_rdata(cart_rdata),
    .uc_req(uc_req), .uc_we(uc_we), .uc_addr(uc_addr), .uc_wdata(uc_wdata),
    .uc_rdata(uc_rdata), .uc_ack(uc_ack),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_drive(ram_drive), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .busy(busy), .cart_overrun(cart_overrun)
  );

  always #5 clk = ~clk;

  // SRAM model
  always @(posedge clk) if (!ram_we_n) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = ram_oe_n ? 8'h00 : mem[ram_addr];

  // Write and read strobes must never be low together
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      n_chk++;
      if (!ram_we_n && !ram_oe_n) begin
        n_fail++;
        $display("FAIL strobe_overlap: we_n=%b oe_n=%b at %0t, need never both 0", ram_we_n, ram_oe_n, $time);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_busy(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      tick(1);
      if (busy === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    n_chk++;
    if ({ram_oe_n, ram_we_n, ram_drive, busy, uc_ack, cart_overrun} !== 6'b110000) begin
      n_fail++;
      $display("FAIL reset_ctrl: oe_n,we_n,drive,busy,ack,ovr=%b need 110000",
               {ram_oe_n, ram_we_n, ram_drive, busy, uc_ack, cart_overrun});
    end
    n_chk++;
    if (cart_rdata !== 8'h00 || uc_rdata !== 8'h00 || ram_addr !== 15'h0 || ram_wdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: crd=%h ucrd=%h addr=%h wd=%h need all 0", cart_rdata, uc_rdata, ram_addr, ram_wdata);
    end
    reset = 1'b0;
    tick(3);
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b need 0", busy); end
  endtask

  task automatic test_cart_write();
    bit ok;
    logic exp_we;
    cart_addr = 15'h1234; cart_wdata = 8'hA5; cart_wr = 1'b1; fi2 = 1'b1;
    wait_busy(10, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL cwr_start: busy=%b never rose, need 1", busy); end
    for (int k = 0; k < 4; k++) begin
      exp_we = (k == 1 || k == 2) ? 1'b0 : 1'b1;
      n_chk++;
      if (busy !== 1'b1 || ram_drive !== 1'b1 || ram_oe_n !== 1'b1 ||
          ram_addr !== 15'h1234 || ram_wdata !== 8'hA5) begin
        n_fail++;
        $display("FAIL cwr_bus[%0d]: busy=%b drive=%b oe_n=%b addr=%h wd=%h need 1 1 1 1234 a5",
                 k, busy, ram_drive, ram_oe_n, ram_addr, ram_wdata);
      end
      n_chk++;
      if (ram_we_n !== exp_we) begin
        n_fail++; $display("FAIL cwr_we[%0d]: we_n=%b need %b", k, ram_we_n, exp_we);
      end
      tick(1);
    end
    cart_wr = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || ram_drive !== 1'b0 || ram_we_n !== 1'b1 || ram_addr !== 15'h1234) begin
      n_fail++;
      $display("FAIL cwr_end: busy=%b drive=%b we_n=%b addr=%h need 0 0 1 1234", busy, ram_drive, ram_we_n, ram_addr);
    end
    tick(6); fi2 = 1'b0; tick(12);
  endtask

  task automatic test_cart_read();
    bit ok;
    cart_addr = 15'h1234; cart_rd = 1'b1; fi2 = 1'b1;
    wait_busy(10, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL crd_start: busy=%b never rose, need 1", busy); end
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (ram_oe_n !== 1'b0 || ram_drive !== 1'b0 || ram_we_n !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL crd_bus[%0d]: oe_n=%b drive=%b we_n=%b busy=%b need 0 0 1 1", k, ram_oe_n, ram_drive, ram_we_n, busy);
      end
      if (k == 2) begin
        n_chk++;
        if (cart_rdata !== 8'h00) begin n_fail++; $display("FAIL crd_early: cart_rdata=%h need 00", cart_rdata); end
      end
      if (k == 3) begin
        n_chk++;
        if (cart_rdata !== 8'hA5) begin n_fail++; $display("FAIL crd_data: cart_rdata=%h need a5", cart_rdata); end
      end
      tick(1);
    end
    cart_rd = 1'b0;
    n_chk++;
    if (ram_oe_n !== 1'b1 || cart_rdata !== 8'hA5) begin
      n_fail++; $display("FAIL crd_hold: oe_n=%b cart_rdata=%h need 1 a5", ram_oe_n, cart_rdata);
    end
    tick(6); fi2 = 1'b0; tick(12);
  endtask

  task automatic test_uc_collision();
    bit ok;
    logic exp_we;
    uc_we = 1'b1; uc_addr = 15'h7FFF; uc_wdata = 8'h3C; uc_req = 1'b1;
    fi2 = 1'b1; tick(12); fi2 = 1'b0;
    wait_busy(10, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL col_start: uc access never began"); end
    // cart request arrives while the uc write is under way
    cart_addr = 15'h0100; cart_wdata = 8'h5A; cart_wr = 1'b1; fi2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_we = (k == 1 || k == 2) ? 1'b0 : 1'b1;
      n_chk++;
      if (busy !== 1'b1 || ram_addr !== 15'h7FFF || ram_wdata !== 8'h3C || ram_drive !== 1'b1 ||
          ram_we_n !== exp_we || uc_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL col_uc[%0d]: busy=%b addr=%h wd=%h drive=%b we_n=%b ack=%b need 1 7fff 3c 1 %b 0",
                 k, busy, ram_addr, ram_wdata, ram_drive, ram_we_n, uc_ack, exp_we);
      end
      tick(1);
    end
    n_chk++;
    if (busy !== 1'b0 || uc_ack !== 1'b1) begin
      n_fail++; $display("FAIL col_gap: busy=%b ack=%b need 0 1", busy, uc_ack);
    end
    tick(1);
    n_chk++;
    if (busy !== 1'b1 || ram_addr !== 15'h0100 || ram_wdata !== 8'h5A || ram_drive !== 1'b1 || uc_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL col_cart: busy=%b addr=%h wd=%h drive=%b ack=%b need 1 0100 5a 1 1",
               busy, ram_addr, ram_wdata, ram_drive, uc_ack);
    end
    cart_wr = 1'b0; uc_req = 1'b0;
    tick(1);
    n_chk++;
    if (uc_ack !== 1'b0) begin n_fail++; $display("FAIL col_ackfall: ack=%b need 0", uc_ack); end
    tick(3);
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL col_end: busy=%b need 0", busy); end
    tick(4); fi2 = 1'b0; tick(12);
  endtask

  task automatic test_uc_hold();
    bit ok;
    bit saw_busy;
    uc_we = 1'b0; uc_addr = 15'h7FFF; uc_req = 1'b1;
    fi2 = 1'b1; tick(12); fi2 = 1'b0;
    wait_busy(10, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL hold_start: uc read never began"); end
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (ram_oe_n !== 1'b0 || ram_drive !== 1'b0 || ram_addr !== 15'h7FFF) begin
        n_fail++; $display("FAIL hold_bus[%0d]: oe_n=%b drive=%b addr=%h need 0 0 7fff", k, ram_oe_n, ram_drive, ram_addr);
      end
      tick(1);
    end
    n_chk++;
    if (uc_ack !== 1'b1 || uc_rdata !== 8'h3C) begin
      n_fail++; $display("FAIL hold_data: ack=%b uc_rdata=%h need 1 3c", uc_ack, uc_rdata);
    end
    saw_busy = 1'b0;
    for (int c = 0; c < 2; c++) begin
      fi2 = 1'b1;
      for (int i = 0; i < 12; i++) begin tick(1); if (busy) saw_busy = 1'b1; end
      fi2 = 1'b0;
      for (int i = 0; i < 12; i++) begin tick(1); if (busy) saw_busy = 1'b1; end
    end
    n_chk++;
    if (saw_busy || uc_ack !== 1'b1) begin
      n_fail++; $display("FAIL hold_block: saw_busy=%b ack=%b need 0 1", saw_busy, uc_ack);
    end
    uc_req = 1'b0;
    tick(2);
    n_chk++;
    if (uc_ack !== 1'b0) begin n_fail++; $display("FAIL hold_release: ack=%b need 0", uc_ack); end
    uc_req = 1'b1;
    fi2 = 1'b1; tick(12); fi2 = 1'b0;
    wait_busy(10, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL hold_rearm: new uc access never began"); end
    tick(4);
    n_chk++;
    if (uc_ack !== 1'b1 || uc_rdata !== 8'h3C || busy !== 1'b0) begin
      n_fail++; $display("FAIL hold_second: ack=%b uc_rdata=%h busy=%b need 1 3c 0", uc_ack, uc_rdata, busy);
    end
    uc_req = 1'b0;
    tick(12);
  endtask

  task automatic test_overrun();
    n_chk++;
    if (cart_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_pre: overrun=%b need 0", cart_overrun); end
    cart_addr = 15'h1234; cart_rd = 1'b1;
    for (int c = 0; c < 8; c++) begin fi2 = 1'b1; tick(2); fi2 = 1'b0; tick(2); end
    cart_rd = 1'b0;
    tick(20);
    n_chk++;
    if (cart_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: overrun=%b need 1", cart_overrun); end
    fi2 = 1'b1; tick(12); fi2 = 1'b0; tick(12);
    n_chk++;
    if (cart_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: overrun=%b need 1", cart_overrun); end
  endtask

  task automatic test_reset_mid_access();
    bit ok;
    cart_addr = 15'h0200; cart_wdata = 8'h77; cart_wr = 1'b1; fi2 = 1'b1;
    wait_busy(10, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL rst_start: access never began"); end
    tick(1);
    n_chk++;
    if (ram_we_n !== 1'b0 || ram_drive !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre: we_n=%b drive=%b need 0 1", ram_we_n, ram_drive);
    end
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if (ram_we_n !== 1'b1 || ram_drive !== 1'b0 || ram_oe_n !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: we_n=%b drive=%b oe_n=%b busy=%b need 1 0 1 0", ram_we_n, ram_drive, ram_oe_n, busy);
    end
    n_chk++;
    if (cart_overrun !== 1'b0) begin n_fail++; $display("FAIL rst_ovr: overrun=%b need 0", cart_overrun); end
    cart_wr = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(6);
    n_chk++;
    if (busy !== 1'b0 || uc_ack !== 1'b0 || ram_we_n !== 1'b1) begin
      n_fail++; $display("FAIL rst_after: busy=%b ack=%b we_n=%b need 0 0 1", busy, uc_ack, ram_we_n);
    end
    fi2 = 1'b0; tick(6);
  endtask

  initial begin
    test_reset();
    test_cart_write();
    test_cart_read();
    test_uc_collision();
    test_uc_hold();
    test_overrun();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
